pkt_pair_feeder: RTL and testbench

Upstream feeder for the dual-enqueue packet FIFO. Accepts two independent valid/ready packet streams, arbitrates per packet (a packet is never interleaved with another), and packs up to two consecutive words of the granted packet into the FIFO's A/B enqueue lanes per cycle. Each FIFO word carries the payload plus a `last` flag in its MSB.

---
 rtl/pkt_pair_feeder.sv | 192 +++++++++++++++++++
 tb/tb_pkt_pair_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_pair_feeder.sv
// pkt_pair_feeder: upstream feeder for the dual-enqueue packet FIFO.
// Two valid/ready sources each fill a 2-entry in-order holding buffer. A
// per-packet round-robin arbiter grants one source at a time. The granted
// buffer is packed onto the A (older) and B (younger) enqueue lanes, up to
// two words per cycle. FIFO word format is {last, payload}.
module pkt_pair_feeder #(
    parameter int DWIDTH   = 32,
    parameter int HOLD_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DWIDTH-2:0] s0_data,
    input  logic              s0_last,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DWIDTH-2:0] s1_data,
    input  logic              s1_last,
    input  logic              fifo_in_valid,
    output logic              outA_enque_en,
    output logic [DWIDTH-1:0] outA_data,
    output logic              outB_enque_en,
    output logic [DWIDTH-1:0] outB_data,
    output logic [31:0]       pkt_count
);

    localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
    localparam int LAST = DWIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [31:0]       pkt_count_q, pkt_count_d;

    // Per-source holding buffer: w0 is the oldest entry.
    logic [DWIDTH-1:0] w0_q [2];
    logic [DWIDTH-1:0] w0_d [2];
    logic [DWIDTH-1:0] w1_q [2];
    logic [DWIDTH-1:0] w1_d [2];
    logic [1:0]        cnt_q [2];
    logic [1:0]        cnt_d [2];

    logic [DWIDTH-1:0] in_word [2];
    logic              rdy [2];
    logic              push [2];
    logic [1:0]        pop_src [2];

    logic              sel;
    logic [DWIDTH-1:0] head0, head1;
    logic [1:0]        head_cnt;
    logic [1:0]        pop;
    logic              hold_inc;
    logic              emit_last;

    assign in_word[0] = {s0_last, s0_data};
    assign in_word[1] = {s1_last, s1_data};

    // Ready depends only on registered occupancy, never on the FIFO side.
    assign rdy[0]   = ~rst & (cnt_q[0] != 2'd2);
    assign rdy[1]   = ~rst & (cnt_q[1] != 2'd2);
    assign push[0]  = s0_valid & rdy[0];
    assign push[1]  = s1_valid & rdy[1];
    assign s0_ready = rdy[0];
    assign s1_ready = rdy[1];

    // Emission decision for the granted buffer: how many words to pop this cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sel      = (state_q == ST_G1);
        head0    = w0_q[sel];
        head1    = w1_q[sel];
        head_cnt = cnt_q[sel];
        pop      = 2'd0;
        hold_inc = 1'b0;
        if (state_q != ST_IDLE && fifo_in_valid) begin
            if (head_cnt == 2'd2) begin
                // A last word on w0 means w1 opens the next packet: never pair them.
                pop = head0[LAST] ? 2'd1 : 2'd2;
            end else if (head_cnt == 2'd1) begin
                if (head0[LAST] || hold_q == HOLD_LIM) begin
                    pop = 2'd1;
                end else begin
                    hold_inc = 1'b1;
                end
            end
        end
        emit_last  = (pop == 2'd1 && head0[LAST]) || (pop == 2'd2 && head1[LAST]);
        pop_src[0] = (state_q == ST_G0) ? pop : 2'd0;
        pop_src[1] = (state_q == ST_G1) ? pop : 2'd0;
    end

    // Arbiter FSM, round-robin pointer, hold timer and packet counter.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        hold_d      = hold_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (cnt_q[0] != 2'd0 && cnt_q[1] != 2'd0) begin
                    state_d = rr_q ? ST_G1 : ST_G0;
                end else if (cnt_q[0] != 2'd0) begin
                    state_d = ST_G0;
                end else if (cnt_q[1] != 2'd0) begin
                    state_d = ST_G1;
                end
            end
            ST_G0, ST_G1: begin
                if (emit_last) begin
                    state_d = ST_IDLE;
                    rr_d    = ~sel;
                    hold_d  = '0;
                end else if (pop != 2'd0) begin
                    hold_d = '0;
                end else if (hold_inc) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (emit_last) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    // Buffer update: apply this cycle's pop first, then append the pushed word.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w0_d[s]  = w0_q[s];
            w1_d[s]  = w1_q[s];
            cnt_d[s] = cnt_q[s];
            if (pop_src[s] == 2'd2) begin
                cnt_d[s] = 2'd0;
            end else if (pop_src[s] == 2'd1) begin
                w0_d[s]  = w1_q[s];
                cnt_d[s] = cnt_q[s] - 2'd1;
            end
            if (push[s]) begin
                if (cnt_d[s] == 2'd0) begin
                    w0_d[s] = in_word[s];
                end else begin
                    w1_d[s] = in_word[s];
                end
                cnt_d[s] = cnt_d[s] + 2'd1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            hold_q      <= '0;
            pkt_count_q <= '0;
            // NOTE: buffer payloads are reset with the counts so no X can reach the lanes.
            for (int s = 0; s < 2; s++) begin
                w0_q[s]  <= '0;
                w1_q[s]  <= '0;
                cnt_q[s] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            hold_q      <= hold_d;
            pkt_count_q <= pkt_count_d;
            for (int s = 0; s < 2; s++) begin
                w0_q[s]  <= w0_d[s];
                w1_q[s]  <= w1_d[s];
                cnt_q[s] <= cnt_d[s];
            end
        end
    end

    // Lanes are driven only while enabled, so data reads 0 in reset and when idle.
    assign outA_enque_en = (pop != 2'd0);
    assign outB_enque_en = (pop == 2'd2);
    assign outA_data     = outA_enque_en ? head0 : '0;
    assign outB_data     = outB_enque_en ? head1 : '0;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_pkt_pair_feeder.sv
// Bench for pkt_pair_feeder: directed cycle tables, corner-case sequences
// and a randomized run checked against a queue-based packet scoreboard.
module tb_pkt_pair_feeder;

    localparam logic [31:0] LF = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s0_last;
    logic [30:0] s0_data;
    logic        s1_valid, s1_ready, s1_last;
    logic [30:0] s1_data;
    logic        fifo_in_valid;
    logic        outA_enque_en, outB_enque_en;
    logic [31:0] outA_data, outB_data, pkt_count;
    logic        h0_s0_ready, h0_s1_ready, h0_a_en, h0_b_en;
    logic [31:0] h0_a_d, h0_b_d, h0_pc;

    always #5 clk = ~clk;

    pkt_pair_feeder #(.DWIDTH(32), .HOLD_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .fifo_in_valid(fifo_in_valid),
        .outA_enque_en(outA_enque_en), .outA_data(outA_data),
        .outB_enque_en(outB_enque_en), .outB_data(outB_data),
        .pkt_count(pkt_count)
    );

    pkt_pair_feeder #(.DWIDTH(32), .HOLD_MAX(0)) dut_h0 (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(h0_s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(h0_s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .fifo_in_valid(fifo_in_valid),
        .outA_enque_en(h0_a_en), .outA_data(h0_a_d),
        .outB_enque_en(h0_b_en), .outB_data(h0_b_d),
        .pkt_count(h0_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard state ----------------
    typedef logic [31:0] wq_t[$];
    wq_t src_q [2];   // words accepted by the DUT, not yet enqueued
    wq_t tx_q  [2];   // words waiting to be offered by each source
    int  cur_src;     // source of the packet in flight, -1 when none
    bit  prev_last;
    int  model_pkts;
    int  first_src;
    int  seq_ctr = 0;

    task automatic reset_model();
        for (int s = 0; s < 2; s++) begin
            src_q[s].delete();
            tx_q[s].delete();
        end
        cur_src    = -1;
        prev_last  = 1'b0;
        model_pkts = 0;
        first_src  = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
        fifo_in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {s0_ready, s1_ready, h0_s0_ready, h0_s1_ready}, 4'b0000);
        check("rst_en", {outA_enque_en, outB_enque_en, h0_a_en, h0_b_en}, 4'b0000);
        check("rst_data", {outA_data, outB_data}, 64'd0);
        check("rst_h0_data", {h0_a_d, h0_b_d}, 64'd0);
        check("rst_pkt_count", {pkt_count, h0_pc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    // Packet words carry the source id in payload bit 30 and a running sequence number.
    task automatic add_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) begin
            tx_q[s].push_back({(k == len - 1), s[0], seq_ctr[29:0]});
            seq_ctr++;
        end
    endtask

    // One clock cycle: drive sources, check DUT against packet-level rules, commit pushes.
    task automatic step(input bit fv, input int vprob);
        bit          pv [2];
        bit          exp_rdy [2];
        bit          emitted_last;
        int          s;
        logic [31:0] wa, wb;
        for (int i = 0; i < 2; i++) begin
            pv[i] = (tx_q[i].size() > 0) && ($urandom_range(99) < vprob);
        end
        s0_valid = pv[0];
        {s0_last, s0_data} = pv[0] ? tx_q[0][0] : 32'($urandom);
        s1_valid = pv[1];
        {s1_last, s1_data} = pv[1] ? tx_q[1][0] : 32'($urandom);
        fifo_in_valid = fv;
        #1;
        for (int i = 0; i < 2; i++) exp_rdy[i] = (src_q[i].size() < 2);
        check("ready0", s0_ready, exp_rdy[0]);
        check("ready1", s1_ready, exp_rdy[1]);
        check("pkt_count", pkt_count, model_pkts);
        if (!fv) check("stall_en", {outA_enque_en, outB_enque_en}, 2'b00);
        check("B_without_A", outB_enque_en & ~outA_enque_en, 1'b0);
        check("switch_bubble", prev_last & outA_enque_en, 1'b0);
        emitted_last = 1'b0;
        if (outA_enque_en) begin
            s = int'(outA_data[30]);
            if (cur_src >= 0) check("pkt_interleave", s, cur_src);
            if (first_src < 0) first_src = s;
            check("A_has_word", src_q[s].size() > 0, 1'b1);
            if (src_q[s].size() > 0) begin
                wa = src_q[s].pop_front();
                check("A_data", outA_data, wa);
                emitted_last = wa[31];
                if (outB_enque_en) begin
                    check("B_after_last", wa[31], 1'b0);
                    check("B_has_word", src_q[s].size() > 0, 1'b1);
                    if (src_q[s].size() > 0) begin
                        wb = src_q[s].pop_front();
                        check("B_data", outB_data, wb);
                        emitted_last = wb[31];
                    end
                end else if (!wa[31]) begin
                    check("pair_missed", src_q[s].size(), 0);
                end
            end
            if (emitted_last) begin
                model_pkts++;
                cur_src = -1;
            end else begin
                cur_src = s;
            end
        end
        prev_last = emitted_last;
        for (int i = 0; i < 2; i++) begin
            if (pv[i] && exp_rdy[i]) src_q[i].push_back(tx_q[i].pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int fv_prob, input int vprob, input int budget);
        int n = 0;
        while ((tx_q[0].size() + tx_q[1].size() + src_q[0].size() + src_q[1].size()) > 0
               && n < budget) begin
            step($urandom_range(99) < fv_prob, vprob);
            n++;
        end
        check("drain_left", tx_q[0].size() + tx_q[1].size() + src_q[0].size() + src_q[1].size(), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 100);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rb;
        bit          v0;
        logic [30:0] d0;
        bit          l0;
        bit          v1;
        logic [30:0] d1;
        bit          l1;
        bit          r0, r1;
        bit          a_en;
        logic [31:0] a_d;
        bit          b_en;
        logic [31:0] b_d;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit rb, bit v0, logic [30:0] d0, bit l0,
                                bit v1, logic [30:0] d1, bit l1, bit r0, bit r1,
                                bit ae, logic [31:0] ad, bit be, logic [31:0] bd,
                                logic [31:0] pc);
        vec_t v;
        v.rb = rb; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.r0 = r0; v.r1 = r1; v.a_en = ae; v.a_d = ad; v.b_en = be; v.b_d = bd; v.pc = pc;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single 4-word packet on s0.
        vecs.push_back(mk(1, 1, 31'h1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'h2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'h3, 0, 0, 0, 0, 0, 1, 1, 32'h1, 1, 32'h2, 0));
        vecs.push_back(mk(0, 1, 31'h3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'h4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3, 1, LF | 32'h4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        // Both sources start a 3-word packet together.
        vecs.push_back(mk(1, 1, 31'h10, 0, 1, 31'h20, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'h11, 0, 1, 31'h21, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'h12, 1, 1, 31'h22, 1, 0, 0, 1, 32'h10, 1, 32'h11, 0));
        vecs.push_back(mk(0, 1, 31'h12, 1, 1, 31'h22, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 31'h22, 1, 1, 0, 1, LF | 32'h12, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 31'h22, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 31'h22, 1, 1, 0, 1, 32'h20, 1, 32'h21, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 31'h22, 1, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, LF | 32'h22, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2));
        // Buffer [0xA+last, 0xB]: A sent alone, 0xB re-granted then held 3 cycles.
        vecs.push_back(mk(1, 1, 31'hA, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 31'hB, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, LF | 32'hA, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hB, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

        rst = 1'b1;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
        fifo_in_valid = 1'b0;
        reset_model();

        foreach (vecs[i]) begin
            if (vecs[i].rb) do_reset();
            s0_valid = vecs[i].v0; s0_data = vecs[i].d0; s0_last = vecs[i].l0;
            s1_valid = vecs[i].v1; s1_data = vecs[i].d1; s1_last = vecs[i].l1;
            fifo_in_valid = 1'b1;
            #1;
            check($sformatf("row%0d_ready", i), {s0_ready, s1_ready}, {vecs[i].r0, vecs[i].r1});
            check($sformatf("row%0d_A_en", i), outA_enque_en, vecs[i].a_en);
            if (vecs[i].a_en) check($sformatf("row%0d_A_data", i), outA_data, vecs[i].a_d);
            check($sformatf("row%0d_B_en", i), outB_enque_en, vecs[i].b_en);
            if (vecs[i].b_en) check($sformatf("row%0d_B_data", i), outB_data, vecs[i].b_d);
            check($sformatf("row%0d_pkt_count", i), pkt_count, vecs[i].pc);
            @(posedge clk); #1;
        end

        // Lone non-last word with HOLD_MAX=0 goes out in the first granted cycle.
        do_reset();
        s0_valid = 1'b1; s0_data = 31'h5; s0_last = 1'b0; fifo_in_valid = 1'b1;
        #1;
        check("h0_ready", {h0_s0_ready, h0_s1_ready}, 2'b11);
        check("h0_c0_en", h0_a_en, 1'b0);
        @(posedge clk); #1;
        s0_valid = 1'b0;
        #1;
        check("h0_idle_en", h0_a_en, 1'b0);
        @(posedge clk); #1;
        check("h0_emit", {h0_a_en, h0_a_d, h0_b_en}, {1'b1, 32'h5, 1'b0});
        check("hold3_waiting", outA_enque_en, 1'b0);
        @(posedge clk); #1;
        check("h0_after", h0_a_en, 1'b0);

        // fifo_in_valid low for 5 cycles mid-packet.
        do_reset();
        add_pkt(0, 6);
        add_pkt(1, 4);
        step(1'b1, 100);
        step(1'b1, 100);
        for (int k = 0; k < 5; k++) step(1'b0, 100);
        check("stall_full_ready", {s0_ready, s1_ready}, 2'b00);
        drain(100, 100, 200);

        // Reset pulse mid-packet, then a fresh start from source 0.
        do_reset();
        add_pkt(0, 1);
        add_pkt(0, 5);
        for (int k = 0; k < 5; k++) step(1'b1, 100);
        rst = 1'b1;
        #1;
        check("midrst_ready", {s0_ready, s1_ready}, 2'b00);
        check("midrst_en", {outA_enque_en, outB_enque_en}, 2'b00);
        check("midrst_data", {outA_data, outB_data}, 64'd0);
        check("midrst_pkt_count", pkt_count, 32'd0);
        @(posedge clk); #1;
        check("midrst_edge_en", {outA_enque_en, outB_enque_en}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        add_pkt(0, 3);
        add_pkt(1, 3);
        drain(100, 100, 200);
        check("midrst_first_src", first_src, 0);
        check("midrst_pkts", pkt_count, 32'd2);

        // Randomized traffic with FIFO back-pressure.
        do_reset();
        for (int p = 0; p < 25; p++) begin
            add_pkt(0, $urandom_range(1, 5));
            add_pkt(1, $urandom_range(1, 5));
        end
        drain(75, 70, 5000);
        check("rand_pkts", pkt_count, 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
